// File: rtl/vram_arbiter.sv
// ============================================================================
// Module   : vram_arbiter
// Brief    : Text VRAM owner arbitrating display fetches, FIFO-posted writes
//            and a clear-screen fill sequence onto one synchronous RAM port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vram_arbiter #(
    parameter int                ADDR_W    = 13,
    parameter int                DATA_W    = 8,
    parameter int                CELLS     = 4800,
    parameter int                FIFO_AW   = 2,
    parameter logic [DATA_W-1:0] FILL_CHAR = 8'h20
) (
    input  logic              clk_50,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clear_start,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int DEPTH = 2 ** FIFO_AW;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t r_state, w_state_nxt;

    logic [ADDR_W+DATA_W-1:0] r_fifo [DEPTH];
    logic [FIFO_AW-1:0]       r_wptr, r_rptr;
    logic [FIFO_AW:0]         r_count, w_count_nxt;
    logic                     w_empty, w_full, w_push, w_pop;
    logic                     w_gnt_disp, w_gnt_fifo, w_gnt_clr;
    logic [ADDR_W-1:0]        r_clr_ptr;
    logic                     w_clr_last;
    logic [ADDR_W-1:0]        w_head_addr;
    logic [DATA_W-1:0]        w_head_data;
    logic                     r_rd_issue, r_rd_ret;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == (FIFO_AW+1)'(DEPTH));
    assign wr_ready = !rst && !w_full && (r_state == ST_IDLE);
    assign w_push   = wr_valid && wr_ready;

    // Display always wins; the FIFO is only served outside CLEAR.
    assign w_gnt_disp = disp_req;
    assign w_gnt_fifo = !disp_req && !w_empty && (r_state != ST_CLEAR);
    assign w_gnt_clr  = !disp_req && (r_state == ST_CLEAR);
    assign w_pop      = w_gnt_fifo;
    assign w_clr_last = (r_clr_ptr == ADDR_W'(CELLS - 1));

    assign {w_head_addr, w_head_data} = r_fifo[r_rptr];

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                // A write accepted alongside clear_start must land before the fill.
                if (clear_start) begin
                    w_state_nxt = (w_count_nxt != '0) ? ST_DRAIN : ST_CLEAR;
                end
            end
            ST_DRAIN: begin
                if (w_count_nxt == '0) begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (w_gnt_clr && w_clr_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            busy    <= (w_state_nxt != ST_IDLE);
        end
    end

    always_ff @(posedge clk_50) begin
        if (w_push) begin
            r_fifo[r_wptr] <= {wr_addr, wr_data};
        end
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            r_clr_ptr <= '0;
        end else if ((r_state != ST_CLEAR) && (w_state_nxt == ST_CLEAR)) begin
            r_clr_ptr <= '0;
        end else if (w_gnt_clr) begin
            r_clr_ptr <= w_clr_last ? '0 : r_clr_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_en <= w_gnt_disp || w_gnt_fifo || w_gnt_clr;
            mem_we <= w_gnt_fifo || w_gnt_clr;
            if (w_gnt_disp) begin
                mem_addr <= disp_addr;
            end else if (w_gnt_fifo) begin
                mem_addr  <= w_head_addr;
                mem_wdata <= w_head_data;
            end else if (w_gnt_clr) begin
                mem_addr  <= r_clr_ptr;
                mem_wdata <= FILL_CHAR;
            end
        end
    end

    // Read return pipe: issue (c+1), RAM data (c+2), captured output (c+3).
    always_ff @(posedge clk_50) begin
        if (rst) begin
            r_rd_issue <= 1'b0;
            r_rd_ret   <= 1'b0;
            disp_valid <= 1'b0;
            disp_data  <= '0;
        end else begin
            r_rd_issue <= w_gnt_disp;
            r_rd_ret   <= r_rd_issue;
            disp_valid <= r_rd_ret;
            if (r_rd_ret) begin
                disp_data <= mem_rdata;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vram_arbiter.sv
// ============================================================================
// Module   : tb_vram_arbiter
// Brief    : Directed self-checking bench for vram_arbiter with a RAM model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vram_arbiter;

    logic        clk_50 = 1'b0;
    logic        rst = 1'b1;
    logic        disp_req = 1'b0;
    logic [12:0] disp_addr = '0;
    logic        disp_valid;
    logic [7:0]  disp_data;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [12:0] wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        clear_start = 1'b0;
    logic        busy;
    logic        mem_en, mem_we;
    logic [12:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic [7:0]  ram [8192];
    logic        bd_fill = 1'b0;
    logic        bd_we = 1'b0;
    logic [12:0] bd_addr = '0;
    logic [7:0]  bd_val = '0;

    int errors = 0;
    int checks = 0;

    vram_arbiter dut (
        .clk_50(clk_50), .rst(rst),
        .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_valid(disp_valid), .disp_data(disp_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .clear_start(clear_start), .busy(busy),
        .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk_50 = ~clk_50;

    // Single-port synchronous-read RAM, plus bench-side preload controls.
    always @(posedge clk_50) begin
        if (bd_fill) begin
            for (int i = 0; i < 8192; i++) ram[i] <= bd_val;
        end else if (bd_we) begin
            ram[bd_addr] <= bd_val;
        end else if (mem_en && mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
    end

    task automatic tick();
        @(posedge clk_50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bd_write(input logic [12:0] a, input logic [7:0] v);
        bd_we = 1'b1; bd_addr = a; bd_val = v;
        tick();
        bd_we = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, bad, nreq, nval, found;
        logic ready_seen;
        logic [20:0] wlog [4];
        int nw;

        // Reset and RAM preload
        bd_fill = 1'b1; bd_val = 8'h00;
        tick();
        bd_fill = 1'b0;
        tick();
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_disp", 32'({disp_valid, disp_data}), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_wr_ready", 32'(wr_ready), 32'd1);
        bd_write(13'd0, 8'h41);
        bd_write(13'd1, 8'h42);
        bd_write(13'd2, 8'h43);
        bd_write(13'd200, 8'h11);
        tick();

        // Display latency: three back-to-back fetches
        for (int i = 0; i < 6; i++) begin
            disp_req  = (i < 3);
            disp_addr = 13'(i);
            tick();
            chk("lat_no_we", 32'(mem_we), 32'd0);
            chk("lat_valid", 32'(disp_valid), 32'((i >= 2) && (i < 5)));
            if (i >= 2 && i < 5) chk("lat_data", 32'(disp_data), 32'(8'h41 + i - 2));
        end

        // FIFO fill while the display hogs the port
        disp_req = 1'b1; disp_addr = 13'd10;
        for (int j = 0; j < 5; j++) begin
            wr_valid = 1'b1; wr_addr = 13'(100 + j); wr_data = 8'(8'hA0 + j);
            #1;
            chk("fill_wr_ready", 32'(wr_ready), 32'(j < 4));
            tick();
            chk("fill_no_we", 32'(mem_we), 32'd0);
        end
        disp_req = 1'b0;
        for (int w = 0; w < 5; w++) begin
            tick();
            if (w == 0) chk("fill_ready_again", 32'(wr_ready), 32'd1);
            if (w == 1) wr_valid = 1'b0;
            chk("fill_order", 32'({mem_en, mem_we, mem_addr, mem_wdata}),
                32'({1'b1, 1'b1, 13'(100 + w), 8'(8'hA0 + w)}));
        end
        tick();
        chk("fill_done", 32'(mem_en), 32'd0);
        repeat (4) tick();

        // Read/write conflict on address 200
        wr_valid = 1'b1; wr_addr = 13'd200; wr_data = 8'h99;
        tick();
        wr_valid = 1'b0; disp_req = 1'b1; disp_addr = 13'd200;
        tick();
        disp_req = 1'b0;
        chk("conf_read_first", 32'({mem_en, mem_we, mem_addr}), 32'({1'b1, 1'b0, 13'd200}));
        tick();
        chk("conf_write_next", 32'({mem_en, mem_we, mem_addr, mem_wdata}),
            32'({1'b1, 1'b1, 13'd200, 8'h99}));
        disp_req = 1'b1;
        tick();
        disp_req = 1'b0;
        chk("conf_old_data", 32'({disp_valid, disp_data}), 32'({1'b1, 8'h11}));
        tick();
        chk("conf_hold", 32'({disp_valid, disp_data}), 32'({1'b0, 8'h11}));
        tick();
        chk("conf_new_data", 32'({disp_valid, disp_data}), 32'({1'b1, 8'h99}));
        repeat (3) tick();

        // Clear with empty FIFO and no display traffic
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        cnt = 0; ready_seen = 1'b0;
        while (busy === 1'b1 && cnt < 6000) begin
            cnt++;
            if (wr_ready) ready_seen = 1'b1;
            tick();
        end
        chk("clr_busy_cycles", 32'(cnt), 32'd4800);
        chk("clr_wr_ready_low", 32'(ready_seen), 32'd0);
        chk("clr_wr_ready_back", 32'(wr_ready), 32'd1);
        tick();
        bad = 0;
        for (int a = 0; a < 4800; a++) if (ram[a] !== 8'h20) bad++;
        chk("clr_ram", 32'(bad), 32'd0);
        chk("clr_ram_beyond", 32'(ram[4800]), 32'd0);

        // Clear behind queued writes with toggling display traffic
        bd_fill = 1'b1; bd_val = 8'h00;
        tick();
        bd_fill = 1'b0;
        tick();
        nreq = 0; nval = 0; nw = 0;
        disp_req = 1'b1; disp_addr = 13'd300;
        for (int k = 0; k < 3; k++) begin
            wr_valid = 1'b1; wr_addr = 13'(5 + k); wr_data = 8'(8'h55 + k);
            nreq++;
            tick();
            if (disp_valid) nval++;
        end
        wr_valid = 1'b0; disp_req = 1'b0; clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        if (disp_valid) nval++;
        if (mem_en && mem_we && nw < 4) begin wlog[nw] = {mem_addr, mem_wdata}; nw++; end
        chk("mix_busy", 32'(busy), 32'd1);
        cnt = 0;
        while (busy === 1'b1 && cnt < 12000) begin
            disp_req = cnt[0];
            disp_addr = 13'(cnt % 4800);
            if (disp_req) nreq++;
            cnt++;
            tick();
            if (disp_valid) nval++;
            if (mem_en && mem_we && nw < 4) begin wlog[nw] = {mem_addr, mem_wdata}; nw++; end
        end
        disp_req = 1'b0;
        repeat (5) begin
            tick();
            if (disp_valid) nval++;
        end
        chk("mix_w0", 32'(wlog[0]), 32'({13'd5, 8'h55}));
        chk("mix_w1", 32'(wlog[1]), 32'({13'd6, 8'h56}));
        chk("mix_w2", 32'(wlog[2]), 32'({13'd7, 8'h57}));
        chk("mix_w3_clear", 32'(wlog[3]), 32'({13'd0, 8'h20}));
        chk("mix_valid_count", 32'(nval), 32'(nreq));
        bad = 0;
        for (int a = 0; a < 4800; a++) if (ram[a] !== 8'h20) bad++;
        chk("mix_ram", 32'(bad), 32'd0);

        // Reset in the middle of a clear
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        found = 0; cnt = 0;
        while (found == 0 && cnt < 300) begin
            if (mem_en && mem_we && mem_addr == 13'd99) found = 1;
            else begin cnt++; tick(); end
        end
        chk("rstclr_reach_100", 32'(found), 32'd1);
        rst = 1'b1;
        tick();
        chk("rstclr_mem_en", 32'(mem_en), 32'd0);
        chk("rstclr_busy", 32'(busy), 32'd0);
        chk("rstclr_wr_ready", 32'(wr_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("rstclr_ready_after", 32'(wr_ready), 32'd1);
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        chk("rstclr_busy_again", 32'(busy), 32'd1);
        tick();
        chk("rstclr_restart0", 32'({mem_en, mem_we, mem_addr, mem_wdata}),
            32'({1'b1, 1'b1, 13'd0, 8'h20}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Owns the single-port, synchronous-read text video RAM: 80x60 character cells, one byte each, 4800 cells total.
- Shares that RAM between two requesters:
  - the display fetch path, driven from the VGA timing counters, which has hard real-time priority;
  - the game-logic writer, which posts writes through an internal FIFO.
- Provides a clear-screen sequencer that fills every cell with a fill character while the display keeps refreshing.

Parameters:
- ADDR_W, 13: cell address width.
- DATA_W, 8: character code width.
- CELLS, 4800: number of cells the clear sequence covers (addresses 0..CELLS-1).
- FIFO_AW, 2: write-FIFO address width; depth = 2**FIFO_AW = 4.
- FILL_CHAR, 8'h20: value written by the clear sequence.

Ports:
- clk_50  in  1  system clock; every register in the block is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- disp_req  in  1  display fetch request; may be high on consecutive cycles.
- disp_addr  in  ADDR_W  cell address for the fetch.
- disp_valid  out  1  one-cycle pulse: disp_data holds the fetched byte.
- disp_data  out  DATA_W  fetched character code.
- wr_valid  in  1  writer has a write to post.
- wr_ready  out  1  FIFO accepts a write this cycle.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- clear_start  in  1  pulse that starts a clear-screen sequence.
- busy  out  1  high while the block is in DRAIN or CLEAR.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data; valid in the cycle after a read is presented.

Behaviour:
- Reset (synchronous, rst high at a clk_50 edge):
  - All of these clear to 0: mem_en, mem_we, mem_addr, mem_wdata, disp_valid, disp_data, busy.
  - FIFO is emptied and the clear pointer is zeroed.
  - State goes to IDLE.
  - wr_ready = 0 while rst is high, and 1 in the first cycle after reset.
  - Reset during CLEAR aborts the clear; RAM contents are left as they are.
- Arbitration, evaluated once per cycle:
  - Priority 1: disp_req.
  - Priority 2: in IDLE or DRAIN, the FIFO head if the FIFO is non-empty.
  - Priority 3: in CLEAR, the clear write.
  - The display is never stalled. The losing requester retries in the next cycle with no loss of data.
- Memory port timing:
  - mem_* are registered.
  - A grant decided in cycle c drives mem_en=1 with the matching mem_we, mem_addr and mem_wdata in cycle c+1.
  - With no grant, mem_en=0 and mem_we=0 in c+1.
- Display latency:
  - disp_req high in cycle c gives a read presented in c+1, mem_rdata valid in c+2, and disp_valid=1 with disp_data registered from mem_rdata in c+3.
  - Latency is fixed at 3 cycles, with throughput of one fetch per cycle.
  - disp_data holds its value when disp_valid=0.
- Write FIFO:
  - A write is accepted when wr_valid && wr_ready at the clock edge.
  - wr_ready = !full && state==IDLE.
  - A pop happens on a FIFO grant.
  - Simultaneous push and pop on a full FIFO is not possible, because wr_ready is 0 when full.
  - Simultaneous push and pop on a non-empty FIFO keeps the count unchanged.
  - The FIFO is first-in first-out, so two writes to the same address land in issue order.
- Ordering: a display read and a write to the same address resolve in grant order. A read granted before the write returns the old data.
- FSM:
  - IDLE:
    - clear_start=1 and FIFO non-empty goes to DRAIN.
    - clear_start=1 and FIFO empty goes to CLEAR with clear_ptr=0.
  - DRAIN: wr_ready=0; goes to CLEAR when the FIFO is empty.
  - CLEAR:
    - Each clear grant writes FILL_CHAR to clear_ptr, then increments clear_ptr.
    - On the grant with clear_ptr==CELLS-1, goes to IDLE.
  - clear_start is ignored outside IDLE.
  - If clear_start and a wr_valid handshake coincide in IDLE, the write is accepted and then drained before the clear.
- busy is registered and equals (state != IDLE). It is high from the cycle after clear_start and falls in the cycle after the last clear grant.
- Clear duration = CELLS plus the number of cycles lost to disp_req. There is no starvation limit; the clear completes during blanking at the latest.

Test Plan:
- Display latency: disp_req high for 3 consecutive cycles with addresses 0, 1, 2 holding 8'h41, 8'h42, 8'h43 → disp_valid high 3 cycles later for 3 cycles with data 41, 42, 43; mem_we=0 throughout.
- FIFO fill: disp_req held high, post 5 writes → wr_ready drops after the 4th accept; no mem_we while disp_req is high; after disp_req drops, 4 writes are issued in order on consecutive cycles, then the 5th.
- Conflict: disp_req and a pending write in the same cycle → the read is issued first and the write on the next free cycle; a read of that address before the write returns old data, and a read after returns new data.
- Clear with empty FIFO: clear_start with disp_req idle → busy high for 4800 cycles; addresses 0..4799 contain 8'h20; wr_ready low during the clear and back to 1 afterwards.
- Clear with pending writes and display traffic: 3 writes queued, clear_start, disp_req toggling 50% → DRAIN writes all 3 first, then the clear; final RAM is all 8'h20; disp_valid count equals disp_req count.
- Reset mid-clear: rst at clear_ptr=100 → the next cycle shows mem_en=0, busy=0, wr_ready=0 while rst is high; after release, wr_ready=1 and a new clear_start restarts at address 0.
